// File: rtl/clock_pkg.sv
// Shared constants and types for the alarm-clock status report path.
// Byte values are ASCII; digit positions are counted from the frame start.
package clock_pkg;

    localparam int FRAME_LEN = 15;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_a  = 8'h61;
    localparam logic [7:0] DOT   = 8'h2E;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_TRIG} alarm_st_e;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} fsm_state_e;

    // Triggered outranks armed; idle and "no flag" share the fallback.
    function automatic alarm_st_e alarm_status(input logic idle, input logic armed,
                                               input logic trig);
        alarm_st_e st;
        if (trig)       st = ST_TRIG;
        else if (armed) st = ST_ARMED;
        else if (idle)  st = ST_IDLE;
        else            st = ST_IDLE;
        return st;
    endfunction

    function automatic logic [7:0] status_char(input alarm_st_e st);
        logic [7:0] c;
        case (st)
            ST_TRIG:  c = CH_T;
            ST_ARMED: c = CH_a;
            default:  c = DOT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its ASCII character; non-decimal codes print as '?'.
module bcd_to_ascii
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    assign ascii = (bcd <= 4'd9) ? (ZERO + {4'd0, bcd}) : QMARK;

endmodule

// File: rtl/clock_report_tx.sv
// Streams a snapshot of time, alarm and alarm state as a 15-byte ASCII frame
// over a valid/ready byte interface. All outputs come straight from flops.
module clock_report_tx
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] di_Mtens,
    input  logic [3:0] di_Mones,
    input  logic [3:0] di_Stens,
    input  logic [3:0] di_Sones,
    input  logic [3:0] di_AMtens,
    input  logic [3:0] di_AMones,
    input  logic [3:0] di_AStens,
    input  logic [3:0] di_ASones,
    input  logic       alarm_idle,
    input  logic       alarm_armed,
    input  logic       alarm_trig,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    fsm_state_e      state, state_nxt;
    logic [3:0]      idx, idx_nxt;
    logic            pending, pending_nxt;
    logic            load;

    logic [7:0][3:0] snap_dig, live_dig, src_dig;
    alarm_st_e       snap_st, live_st, src_st;

    logic [3:0]      dig_sel;
    logic [7:0]      dig_ascii;
    logic [7:0]      byte_nxt;

    // Digit slot 0 is the leftmost character of the frame.
    assign live_dig = {di_ASones, di_AStens, di_AMones, di_AMtens,
                       di_Sones,  di_Stens,  di_Mones,  di_Mtens};
    assign live_st  = alarm_status(alarm_idle, alarm_armed, alarm_trig);

    // On a load cycle the outgoing byte must already reflect the new snapshot.
    assign src_dig = load ? live_dig : snap_dig;
    assign src_st  = load ? live_st  : snap_st;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        load        = 1'b0;
        case (state)
            S_IDLE: begin
                pending_nxt = 1'b0;
                if (go) begin
                    load      = 1'b1;
                    idx_nxt   = 4'd0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (go)
                    pending_nxt = 1'b1;
                if (tx_valid && tx_ready) begin
                    if (idx < LAST_IDX) idx_nxt   = idx + 4'd1;
                    else                state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                idx_nxt     = 4'd0;
                pending_nxt = 1'b0;
                // A go landing in DONE is folded into the same reload.
                if (pending || go) begin
                    load      = 1'b1;
                    state_nxt = S_SEND;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dig_sel = 4'd0;
        case (idx_nxt)
            4'd0:  dig_sel = src_dig[0];
            4'd1:  dig_sel = src_dig[1];
            4'd3:  dig_sel = src_dig[2];
            4'd4:  dig_sel = src_dig[3];
            4'd6:  dig_sel = src_dig[4];
            4'd7:  dig_sel = src_dig[5];
            4'd9:  dig_sel = src_dig[6];
            4'd10: dig_sel = src_dig[7];
            default: dig_sel = 4'd0;
        endcase
    end

    bcd_to_ascii u_digit (
        .bcd   (dig_sel),
        .ascii (dig_ascii)
    );

    always_comb begin
        byte_nxt = dig_ascii;
        case (idx_nxt)
            4'd2, 4'd8:  byte_nxt = COLON;
            4'd5, 4'd11: byte_nxt = SPACE;
            4'd12:       byte_nxt = status_char(src_st);
            4'd13:       byte_nxt = CR;
            4'd14:       byte_nxt = LF;
            default:     byte_nxt = dig_ascii;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            pending    <= 1'b0;
            snap_dig   <= '0;
            snap_st    <= ST_IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            pending    <= pending_nxt;
            if (load) begin
                snap_dig <= live_dig;
                snap_st  <= live_st;
            end
            tx_valid   <= (state_nxt == S_SEND);
            tx_data    <= (state_nxt == S_SEND) ? byte_nxt : 8'h00;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_clock_report_tx.sv
// Randomized scoreboard bench for clock_report_tx: a frame-level model queues
// expected bytes per accepted request; a monitor pops them on each handshake.
module tb_clock_report_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       tx_ready = 1'b0;
    logic [3:0] dg [8];
    logic       a_idle = 1'b0, a_armed = 1'b0, a_trig = 1'b0;
    logic       tx_valid, busy, frame_done;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    clock_report_tx dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .di_Mtens    (dg[0]),
        .di_Mones    (dg[1]),
        .di_Stens    (dg[2]),
        .di_Sones    (dg[3]),
        .di_AMtens   (dg[4]),
        .di_AMones   (dg[5]),
        .di_AStens   (dg[6]),
        .di_ASones   (dg[7]),
        .alarm_idle  (a_idle),
        .alarm_armed (a_armed),
        .alarm_trig  (a_trig),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    // Model phase: 0 = no frame, 1 = sending (rem bytes left), 2 = completion cycle.
    int         ph   = 0;
    int         rem  = 0;
    bit         pend = 1'b0;
    bit         exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dchar(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : 8'h3F;
    endfunction

    task automatic push_frame();
        logic [7:0] f [15];
        logic [7:0] st;
        st = a_trig ? 8'h54 : (a_armed ? 8'h61 : 8'h2E);
        f = '{dchar(dg[0]), dchar(dg[1]), 8'h3A, dchar(dg[2]), dchar(dg[3]), 8'h20,
              dchar(dg[4]), dchar(dg[5]), 8'h3A, dchar(dg[6]), dchar(dg[7]), 8'h20,
              st, 8'h0D, 8'h0A};
        for (int i = 0; i < 15; i++) exp_q.push_back(f[i]);
    endtask

    task automatic step(input bit g, input bit r, input bit rs);
        if (rs) begin
            ph = 0; pend = 1'b0; exp_q.delete();
        end else begin
            case (ph)
                0: if (g) begin push_frame(); ph = 1; rem = 15; end
                1: begin
                    if (g) pend = 1'b1;
                    if (r) begin
                        rem--;
                        if (rem == 0) ph = 2;
                    end
                end
                default: begin
                    if (pend || g) begin
                        push_frame(); ph = 1; rem = 15; pend = 1'b0;
                    end else begin
                        ph = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic rand_in();
        for (int i = 0; i < 8; i++) dg[i] = 4'($urandom_range(0, 12));
        a_idle  = 1'($urandom_range(0, 1));
        a_armed = 1'($urandom_range(0, 1));
        a_trig  = 1'($urandom_range(0, 3) == 0);
    endtask

    // One clock cycle: inputs change just after the edge, model advances with them.
    task automatic cyc(input bit g, input bit r, input bit rs, input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) rand_in();
        go = g; tx_ready = r; rst = rs;
        exp_valid = (ph == 1);
        exp_done  = (ph == 2);
        exp_busy  = (ph != 0);
        step(g, r, rs);
    endtask

    logic [7:0] prev_data = 8'h00;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (mon_en) begin
            chk("tx_valid", tx_valid, exp_valid);
            chk("frame_done", frame_done, exp_done);
            chk("busy", busy, exp_busy);
            if (tx_valid === 1'b1 && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_byte: got %0h, expected no byte (t=%0t)", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e);
                end
            end
            if (prev_stall) chk("stall_hold", tx_data, prev_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready && !rst;
            prev_data  = tx_data;
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 8; i++) dg[i] = 4'd0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        mon_en = 1'b1;

        // 12:34 05:00 armed, ready held high
        dg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd0, 4'd0};
        a_armed = 1'b1; a_trig = 1'b0; a_idle = 1'b0;
        cyc(1, 1, 0, 0);
        repeat (18) cyc(0, 1, 0, 0);

        // ready pattern 1,0,0,1 with inputs churning mid-frame
        cyc(1, 1, 0, 1);
        for (int k = 0; k < 44; k++) cyc(0, (k % 4 == 0) || (k % 4 == 3), 0, 1);

        // three requests during one frame coalesce into one extra frame
        cyc(1, 1, 0, 1);
        for (int k = 0; k < 40; k++)
            cyc((k == 3) || (k == 6) || (k == 9), 1'($urandom_range(0, 1)), 0, 1);
        repeat (40) cyc(0, 1, 0, 1);

        // non-decimal seconds digit and trig outranking armed
        dg = '{4'd2, 4'd3, 4'd5, 4'hA, 4'd0, 4'd7, 4'd3, 4'd0};
        a_trig = 1'b1; a_armed = 1'b1;
        cyc(1, 1, 0, 0);
        repeat (17) cyc(0, 1, 0, 0);

        // reset while byte 7 is presented and a request is pending
        cyc(1, 1, 0, 1);
        repeat (7) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (17) cyc(0, 1, 0, 0);

        // request coincident with the final byte handshake
        cyc(1, 1, 0, 1);
        repeat (14) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (18) cyc(0, 1, 0, 1);

        // random traffic
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 0, 1);

        guard = 0;
        while ((ph != 0 || exp_q.size() != 0) && guard < 200) begin
            cyc(0, 1, 0, 0);
            guard++;
        end
        repeat (2) cyc(0, 1, 0, 0);
        @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
